// File: rtl/aes_pkg.sv
// Shared AES types and constants for the SubBytes engine and its S-box.
// Latency: n/a (types only).
// Backpressure: n/a.
// Contents: byte_t, state_t, sb_state_e FSM encoding, AES_BLOCK_BYTES.
package aes_pkg;

  localparam int AES_BLOCK_BYTES = 16;

  typedef logic [7:0]                   byte_t;
  typedef logic [8*AES_BLOCK_BYTES-1:0] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sb_state_e;

endpackage

// File: rtl/S.sv
// Registered FIPS-197 forward S-box; one lookup per cycle.
// Latency: 1 cycle (input sampled on rising edge, result valid the cycle after).
// Backpressure: none; free-running every cycle, output register is not reset.
// Ports: clk - clock; in - byte to substitute; out - substituted byte (registered).
module S
  import aes_pkg::*;
(
  input  logic  clk,
  input  byte_t in,
  output byte_t out
);

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Deliberately unreset: the engine never consumes this register in the
  // first RUN cycle, so a stale value after reset is never written anywhere.
  always_ff @(posedge clk) begin
    out <= SBOX[in];
  end

endmodule

// File: rtl/aes_sub_bytes_seq.sv
// Byte-serial AES SubBytes (or SubWord with NUM_BYTES=4) sharing one registered S-box.
// Latency: NUM_BYTES+2 cycles from accept to out_valid; block period NUM_BYTES+3.
// Backpressure: result held bit-stable in DONE until out_ready; in_ready low outside IDLE.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_state upstream block;
//        out_valid/out_ready/out_state downstream result; busy high while RUN or DONE.
//        Byte 0 is the most significant byte of in_state/out_state.
module aes_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int NUM_BYTES = AES_BLOCK_BYTES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_BYTES-1:0] in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] out_state,
  output logic                   busy
);

  localparam int W  = 8 * NUM_BYTES;
  localparam int CW = $clog2(NUM_BYTES + 1);

  sb_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    src_q, src_d;
  logic [W-1:0]    res_q, res_d;
  byte_t           sbox_in;
  byte_t           sbox_out;

  S u_sbox (
    .clk (clk),
    .in  (sbox_in),
    .out (sbox_out)
  );

  // Control: IDLE accepts, RUN walks cnt 0..NUM_BYTES, DONE holds the result.
  always_comb begin : fsm_comb
    state_d   = state_q;
    cnt_d     = cnt_q;
    src_d     = src_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          src_d   = in_state;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt_q == CW'(NUM_BYTES)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: byte cnt goes into the S-box; its registered answer arrives one
  // cycle later, so the write lands in byte cnt-1. At cnt=NUM_BYTES the mux
  // matches nothing and the S-box input is simply zero.
  always_comb begin : data_comb
    sbox_in = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (cnt_q == CW'(i)) begin
        sbox_in = src_q[W-1-8*i -: 8];
      end
    end
    res_d = res_q;
    if (state_q == RUN) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (cnt_q == CW'(i + 1)) begin
          res_d[W-1-8*i -: 8] = sbox_out;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      res_q   <= res_d;
    end
  end

  assign out_state = res_q;

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Self-checking bench for aes_sub_bytes_seq (16-byte and 4-byte builds side by side).
// Latency: n/a.
// Backpressure: exercised directly via out_ready.
module tb_aes_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_state, out_state;
  logic         in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [31:0]  in_state4, out_state4;

  int checks = 0;
  int passed = 0;

  logic [7:0] sbox_ref [256];

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;
  vec_t vecs [4];

  always #5 clk = ~clk;

  aes_sub_bytes_seq #(.NUM_BYTES(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready),
    .out_state(out_state), .busy(busy)
  );

  aes_sub_bytes_seq #(.NUM_BYTES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_state(in_state4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_state(out_state4), .busy(busy4)
  );

  // Reference S-box from its definition: GF(2^8) inverse followed by the affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_ref();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      sbox_ref[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] sub_ref(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox_ref[x[127-8*i -: 8]];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Starts and ends on a falling edge. lat counts cycles from the accept edge.
  task automatic run_block(input logic [127:0] blk, output logic [127:0] res, output int lat);
    int guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    in_state = blk;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin @(negedge clk); lat++; end
    res = out_state;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] res, blk, exp_a, blk_b;
    logic [7:0]   perm [256];
    int           lat;
    int           acc16[$], out16[$], acc4[$], out4[$];
    logic [127:0] res16[$];
    logic [31:0]  res4[$];
    bit           stable, rdy_low, vld_high;

    vecs[0] = '{din: 128'h000102030405060708090a0b0c0d0e0f, dout: 128'h637c777bf26b6fc53001672bfed7ab76};
    vecs[1] = '{din: 128'h193de3bea0f4e22b9ac68d2ae9f84808, dout: 128'hd42711aee0bf98f1b8b45de51e415230};
    vecs[2] = '{din: {16{8'h53}},                            dout: {16{8'hed}}};
    vecs[3] = '{din: {16{8'h00}},                            dout: {16{8'h63}}};

    build_ref();

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_state = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b1; in_state4 = '0;

    // Reset held three cycles with noise on in_valid.
    repeat (3) begin
      @(negedge clk);
      in_valid  = 1'($urandom);
      in_valid4 = 1'($urandom);
      in_state  = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clk);
    in_valid = 1'b0; in_valid4 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_state", out_state, '0);
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_busy",      busy,      1'b0);
    check("rst4_out_state", out_state4, '0);

    // Back-to-back with out_ready tied high: latency and block period, both builds.
    in_state  = vecs[0].din; in_valid  = 1'b1;
    in_state4 = 32'hcf4f3c09; in_valid4 = 1'b1;
    for (int c = 0; c < 90; c++) begin
      if (in_ready && in_valid)   acc16.push_back(c);
      if (out_valid)  begin out16.push_back(c); res16.push_back(out_state); end
      if (in_ready4 && in_valid4) acc4.push_back(c);
      if (out_valid4) begin out4.push_back(c); res4.push_back(out_state4); end
      @(negedge clk);
    end
    in_valid = 1'b0; in_valid4 = 1'b0;
    check("b2b16_enough", (acc16.size() >= 2 && out16.size() >= 2), 1'b1);
    if (acc16.size() >= 2 && out16.size() >= 2) begin
      check("lat16",     out16[0] - acc16[0], 18);
      check("period16",  out16[1] - out16[0], 19);
      check("b2b16_res", res16[1], vecs[0].dout);
    end
    check("b2b4_enough", (acc4.size() >= 3 && out4.size() >= 3), 1'b1);
    if (acc4.size() >= 3 && out4.size() >= 3) begin
      check("lat4",       out4[0] - acc4[0], 6);
      check("period4_a",  out4[1] - out4[0], 7);
      check("period4_b",  out4[2] - out4[1], 7);
      check("accept4",    acc4[1] - acc4[0], 7);
      check("res4_first", res4[0], 32'h8a84eb01);
      check("res4_third", res4[2], 32'h8a84eb01);
    end
    repeat (25) @(negedge clk);

    // Known-answer table.
    for (int v = 0; v < 4; v++) begin
      run_block(vecs[v].din, res, lat);
      check($sformatf("vec%0d_data", v), res, vecs[v].dout);
      check($sformatf("vec%0d_lat", v), lat, 18);
    end

    // Every byte value once, shuffled across 16 blocks.
    for (int i = 0; i < 256; i++) perm[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      int j = $urandom_range(i, 0);
      logic [7:0] t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    for (int b = 0; b < 16; b++) begin
      for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = perm[16*b+i];
      run_block(blk, res, lat);
      check($sformatf("sweep%0d", b), res, sub_ref(blk));
    end

    // Backpressure: result held for 10 cycles, competing block ignored.
    out_ready = 1'b0;
    blk   = {$urandom, $urandom, $urandom, $urandom};
    blk_b = ~blk;
    exp_a = sub_ref(blk);
    while (!in_ready) @(negedge clk);
    in_state = blk; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin @(negedge clk); lat++; end
    check("bp_lat", lat, 18);
    stable = 1'b1; rdy_low = 1'b1; vld_high = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (out_state !== exp_a) stable = 1'b0;
      if (in_ready !== 1'b0)   rdy_low = 1'b0;
      if (out_valid !== 1'b1)  vld_high = 1'b0;
      if (k == 3) begin in_state = blk_b; in_valid = 1'b1; end
      if (k == 6) in_valid = 1'b0;
      @(negedge clk);
    end
    check("bp_stable",   stable,   1'b1);
    check("bp_in_ready", rdy_low,  1'b1);
    check("bp_valid",    vld_high, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_idle",  in_ready,  1'b1);
    check("bp_release_valid", out_valid, 1'b0);
    @(negedge clk);
    check("bp_not_queued", busy, 1'b0);

    // Reset in the middle of RUN, at cnt=7.
    blk = {$urandom, $urandom, $urandom, $urandom};
    while (!in_ready) @(negedge clk);
    in_state = blk; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("midrst_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy",  busy,      1'b0);
    check("midrst_clear", out_state, '0);
    run_block({16{8'h53}}, res, lat);
    check("midrst_data", res, {16{8'hed}});
    check("midrst_lat",  lat, 18);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
